// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: control/value inputs and segment/anode outputs of the 7-segment scan driver
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic                    i_enable;
  logic                    i_load;
  logic [4*NUM_DIGITS-1:0] i_value;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [6:0]              o_seg;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_anode;
  logic                    o_frame;
  modport master (output i_enable, i_load, i_value, i_dp, input o_seg, o_dp, o_anode, o_frame);
  modport slave (input i_enable, i_load, i_value, i_dp, output o_seg, o_dp, o_anode, o_frame);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: blanked, time-multiplexed common-anode hex display scanner.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits above 0.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic          i_clk,
  input logic          i_rst,
  seg7_scan_ctrl_if.slave bus
);
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam int CMAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  localparam logic [111:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    en_q, en_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, frame_q, frame_d;
  logic                    en, last, wrap, drv, lz;
  logic [3:0]              nib;
  always_comb begin
    en       = bus.i_enable;
    en_d     = en;
    last     = cnt_q == (state_q == DRIVE ? DLAST : BLAST);
    wrap     = state_q == DRIVE && last && idx_q == ILAST;
    state_d  = !en ? BLANK : last ? (state_q == BLANK ? DRIVE : BLANK) : state_q;
    cnt_d    = (!en || last) ? '0 : cnt_q + 1'b1;
    idx_d    = !en ? '0 : (state_q == DRIVE && last) ? (idx_q == ILAST ? '0 : idx_q + 1'b1) : idx_q;
    shadow_d = bus.i_load ? bus.i_value : shadow_q;
    // the display only refreshes at a frame start, so a frame is never torn
    disp_d   = (en && (!en_q || wrap)) ? shadow_q : disp_q;
    nib      = disp_q[4*idx_q +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz       = idx_q != '0 && (disp_q >> (4*idx_q)) == '0;
`else
    lz       = 1'b0;
`endif
    drv      = en && state_q == DRIVE;
    anode_d  = drv ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d    = (drv && !lz) ? SEG_LUT[7*nib +: 7] : 7'h7F;
    dp_d     = drv ? ~bus.i_dp[idx_q] : 1'b1;
    frame_d  = drv && wrap;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q  <= BLANK;
      idx_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      shadow_q <= '0;
      disp_q   <= '0;
      anode_q  <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  assign bus.o_anode = anode_q;
  assign bus.o_seg   = seg_q;
  assign bus.o_dp    = dp_q;
  assign bus.o_frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed plus randomized checks against a frame-position reference model
module tb_seg7_scan_ctrl;
  localparam int ND = 4, DW = 8, BL = 2, SLOT = DW + BL, FR = ND * SLOT;
  localparam logic [12:0] OFF = {4'hF, 7'h7F, 1'b1, 1'b0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  int pos;
  logic [15:0] m_sh, m_disp;
  logic m_enp;
  logic [6:0] hex [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();
  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [12:0] obs();
    return {bus.o_anode, bus.o_seg, bus.o_dp, bus.o_frame};
  endfunction
  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h (anode/seg/dp/frame) pos=%0d", tag, got, want, pos);
    end
  endtask
  // expected outputs come from the pre-edge frame position; the model then advances one clock
  task automatic tick();
    int dig, s;
    logic blank;
    logic [12:0] e;
    e = OFF;
    if (bus.i_enable) begin
      dig = pos / SLOT;
      s = pos % SLOT;
      if (s >= BL) begin
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = dig > 0 && (m_disp >> (4*dig)) == 16'h0;
`endif
        e = {~(4'b0001 << dig), blank ? 7'h7F : hex[m_disp[4*dig +: 4]], ~bus.i_dp[dig], pos == FR - 1};
      end
      if (!m_enp || pos == FR - 1) m_disp = m_sh;
      pos = (pos + 1) % FR;
    end else pos = 0;
    if (bus.i_load) m_sh = bus.i_value;
    m_enp = bus.i_enable;
    @(posedge clk);
    #1;
    chk("scan", obs(), e);
  endtask
  task automatic run_to(input int p);
    for (int i = 0; i < FR && pos != p; i++) tick();
  endtask
  task automatic load(input logic [15:0] v);
    bus.i_load = 1'b1;
    bus.i_value = v;
    tick();
    bus.i_load = 1'b0;
  endtask
  initial begin
    bus.i_enable = 1'b0;
    bus.i_load = 1'b0;
    bus.i_value = '0;
    bus.i_dp = '0;
    pos = 0;
    m_sh = '0;
    m_disp = '0;
    m_enp = 1'b0;
    #12;
    chk("reset_state", obs(), OFF);
    rst = 1'b0;
    bus.i_enable = 1'b1;
    load(16'h1234);
    repeat (FR) tick();
    run_to(BL + 1);
    chk("first_digit_4", obs(), {4'b1110, 7'b0011001, 1'b1, 1'b0});
    repeat (FR) tick();
    run_to(2*SLOT + BL + 3);
    load(16'hABCD);
    run_to(3*SLOT + BL + 1);
    chk("torn_free_1", obs(), {4'b0111, 7'b1111001, 1'b1, 1'b0});
    run_to(0);
    run_to(BL + 1);
    chk("new_digit_D", obs(), {4'b1110, 7'b0100001, 1'b1, 1'b0});
    run_to(FR - 1);
    load(16'h5678);
    run_to(BL + 1);
    chk("coincident_old", obs(), {4'b1110, 7'b0100001, 1'b1, 1'b0});
    run_to(0);
    run_to(BL + 1);
    chk("coincident_new", obs(), {4'b1110, 7'b0000000, 1'b1, 1'b0});
    run_to(SLOT + BL + 2);
    bus.i_enable = 1'b0;
    tick();
    chk("disable_dark", obs(), OFF);
    repeat (4) tick();
    bus.i_enable = 1'b1;
    repeat (2*FR) tick();
    for (int i = 0; i < 1500; i++) begin
      bus.i_dp = 4'($urandom());
      bus.i_enable = $urandom_range(0, 59) != 0;
      bus.i_load = $urandom_range(0, 15) == 0;
      bus.i_value = 16'($urandom());
      tick();
    end
    bus.i_load = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_dp = '0;
    repeat (2) tick();
    run_to(SLOT + BL + 4);
    #3 rst = 1'b1;
    #1 chk("async_reset", obs(), OFF);
    pos = 0;
    m_sh = '0;
    m_disp = '0;
    m_enp = 1'b0;
    @(posedge clk);
    #1 chk("reset_hold", obs(), OFF);
    #2 rst = 1'b0;
    tick();
    run_to(BL + 1);
    chk("shadow_cleared", obs(), {4'b1110, 7'b1000000, 1'b1, 1'b0});
    repeat (FR) tick();
    load(16'h0050);
    bus.i_dp = 4'b0100;
    run_to(0);
    run_to(2*SLOT + BL + 1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz_digit2", obs(), {4'b1011, 7'h7F, 1'b0, 1'b0});
`else
    chk("lz_digit2", obs(), {4'b1011, 7'b1000000, 1'b0, 1'b0});
`endif
    run_to(SLOT + BL + 1);
    chk("lz_digit1", obs(), {4'b1101, 7'b0010010, 1'b1, 1'b0});
    repeat (FR) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
